// File: rtl/xadc_drp_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// xadc_pkg
//   Shared definitions for the XADC DRP read scheduler:
//     - state_e      : scheduler FSM states (IDLE, ISSUE, WAIT)
//     - ADDR_*       : XADC DRP register addresses used by the ADC consumers
//     - TIMEOUT_DATA : data word returned when DRDY never arrives
//     - idx_width()  : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package xadc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic [6:0]  ADDR_TEMP    = 7'h00;
    localparam logic [6:0]  ADDR_VCCINT  = 7'h01;
    localparam logic [6:0]  ADDR_VAUX3   = 7'h13;

    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xadc_drp_scheduler_if.sv
// ---------------------------------------------------------------------------
// xadc_drp_scheduler_if
//   Bundles the requester side and the XADC DRP side of the scheduler.
//   Requester side : req, req_addr (in), rsp_valid, rsp_data, rsp_err (out)
//   DRP side       : drp_den, drp_daddr (out), drp_do, drp_drdy, eoc (in)
//   Status         : busy (out)
//   modport master : the scheduler itself
//   modport slave  : the surrounding logic (requesters + XADC)
// ---------------------------------------------------------------------------
interface xadc_drp_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 7
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        rsp_valid;
    logic [15:0]            rsp_data;
    logic                   rsp_err;
    logic                   drp_den;
    logic [ADDR_W-1:0]      drp_daddr;
    logic [15:0]            drp_do;
    logic                   drp_drdy;
    logic                   eoc;
    logic                   busy;

    modport master (
        input  req, req_addr, drp_do, drp_drdy, eoc,
        output rsp_valid, rsp_data, rsp_err, drp_den, drp_daddr, busy
    );

    modport slave (
        output req, req_addr, drp_do, drp_drdy, eoc,
        input  rsp_valid, rsp_data, rsp_err, drp_den, drp_daddr, busy
    );
endinterface

// File: rtl/xadc_drp_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Searches req_i starting one past the
//   last winner (ptr_i) and wrapping modulo NREQ.
//   Ports:
//     req_i   : request vector
//     ptr_i   : index of the previous winner
//     grant_o : one-hot grant (all zero when nothing requests)
//     idx_o   : index of the granted requester
//     valid_o : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import xadc_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // k = NREQ wraps back to ptr_i itself, so a lone repeat requester
        // is still served.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/xadc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// xadc_drp_scheduler
//   Shares the single XADC DRP read path between NREQ requesters.
//   Round-robin arbitration, one DEN per transaction, waits for DRDY and
//   aborts with rsp_err=1 / data 16'hFFFF after TIMEOUT cycles without it.
//   With WAIT_EOC=1 a read only starts once an EOC has been seen since the
//   previous transaction completed.
//   Ports:
//     CLK100MHZ : system clock
//     rst_n     : asynchronous active-low reset
//     bus       : requester + DRP signals (xadc_drp_scheduler_if.master)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module xadc_drp_scheduler
    import xadc_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ADDR_W   = 7,
    parameter int TIMEOUT  = 64,
    parameter int WAIT_EOC = 1
) (
    input  logic CLK100MHZ,
    input  logic rst_n,
    xadc_drp_scheduler_if.master bus
);

    localparam int IDX_W = idx_width(NREQ);
    // Holds 0 .. TIMEOUT-1; the exit test fires before the counter can wrap.
    localparam int TMR_W = $clog2(TIMEOUT);

    state_e            state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [NREQ-1:0]   gnt_q;
    logic [TMR_W-1:0]  timer_q;
    logic              eoc_pend_q;
    logic              eoc_pend_d;
    logic              den_q;
    logic [ADDR_W-1:0] daddr_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic              rsp_err_q;
    logic              busy_q;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              can_start;
    logic              timeout_hit;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign sel_addr = bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];

    // The served requester still holds req during its response pulse, so no
    // new grant is evaluated in that cycle; its req only counts again if it
    // is still high one cycle later.
    assign can_start = arb_valid
                     && ((WAIT_EOC == 0) || eoc_pend_q)
                     && (rsp_valid_q == '0);

    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    // A fresh EOC wins over the clear in the response pulse cycle.
    assign eoc_pend_d = bus.eoc | (eoc_pend_q & ~(|rsp_valid_q));

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDX_W'(NREQ - 1);
            gnt_q       <= '0;
            timer_q     <= '0;
            eoc_pend_q  <= 1'b0;
            den_q       <= 1'b0;
            daddr_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            eoc_pend_q  <= eoc_pend_d;
            den_q       <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (can_start) begin
                        gnt_q    <= arb_grant;
                        rr_ptr_q <= arb_idx;
                        daddr_q  <= sel_addr;
                        den_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    // DRDY is checked first so it wins over a coincident timeout.
                    if (bus.drp_drdy) begin
                        rsp_data_q  <= bus.drp_do;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (timeout_hit) begin
                        rsp_data_q  <= TIMEOUT_DATA;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.drp_den   = den_q;
    assign bus.drp_daddr = daddr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xadc_drp_scheduler
//   Two scheduler instances share one clock: u0 free-running (WAIT_EOC=0),
//   u1 EOC-gated (WAIT_EOC=1). A small XADC model answers each DEN with
//   DRDY after a programmable latency (0 = never). When not in fixed mode
//   the model returns 16'h1000 | daddr.
// ---------------------------------------------------------------------------
module tb_xadc_drp_scheduler;
    import xadc_pkg::*;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 7;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n;
    logic rst1_n;

    xadc_drp_scheduler_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) if0 ();
    xadc_drp_scheduler_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) if1 ();

    xadc_drp_scheduler #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .WAIT_EOC(0)
    ) u0 (
        .CLK100MHZ (clk),
        .rst_n     (rst0_n),
        .bus       (if0)
    );

    xadc_drp_scheduler #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .WAIT_EOC(1)
    ) u1 (
        .CLK100MHZ (clk),
        .rst_n     (rst1_n),
        .bus       (if1)
    );

    int checks   = 0;
    int failures = 0;

    // XADC model state, index 0 -> u0, 1 -> u1
    int                m_lat   [2];
    int                m_cnt   [2];
    logic              m_fixed [2];
    logic [15:0]       m_data  [2];
    logic              m_drdy  [2];
    logic [15:0]       m_do    [2];
    logic [ADDR_W-1:0] m_addr  [2];
    logic              man_drdy[2];

    assign if0.drp_drdy = m_drdy[0] | man_drdy[0];
    assign if1.drp_drdy = m_drdy[1] | man_drdy[1];
    assign if0.drp_do   = m_do[0];
    assign if1.drp_do   = m_do[1];

    function automatic logic den_of(input int w);
        return (w == 0) ? if0.drp_den : if1.drp_den;
    endfunction

    function automatic logic [ADDR_W-1:0] daddr_of(input int w);
        return (w == 0) ? if0.drp_daddr : if1.drp_daddr;
    endfunction

    function automatic logic [NREQ-1:0] vld_of(input int w);
        return (w == 0) ? if0.rsp_valid : if1.rsp_valid;
    endfunction

    // DEN seen in cycle c -> DRDY driven during cycle c+lat.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_drdy[i] = 1'b0;
            if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_drdy[i] = 1'b1;
                    m_do[i]   = m_fixed[i] ? m_data[i] : (16'h1000 | 16'(m_addr[i]));
                end
            end
            if (den_of(i) && m_lat[i] > 0) begin
                m_cnt[i]  = m_lat[i];
                m_addr[i] = daddr_of(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic wait_den(input int w, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!den_of(w) && n < lim);
    endtask

    task automatic wait_rsp(input int w, input int lim, output int n, output int dens);
        n    = 0;
        dens = 0;
        do begin
            @(negedge clk);
            n++;
            if (den_of(w)) dens++;
        end while (vld_of(w) == '0 && n < lim);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dens;
        int hits;
        int idx;
        logic [ADDR_W-1:0] addr_tab [4];

        addr_tab[0] = ADDR_VAUX3;
        addr_tab[1] = ADDR_TEMP;
        addr_tab[2] = ADDR_VCCINT;
        addr_tab[3] = 7'h05;

        for (int i = 0; i < 2; i++) begin
            m_lat[i]    = 0;
            m_cnt[i]    = 0;
            m_fixed[i]  = 1'b0;
            m_data[i]   = 16'h0000;
            m_drdy[i]   = 1'b0;
            m_do[i]     = 16'h0000;
            m_addr[i]   = '0;
            man_drdy[i] = 1'b0;
        end
        rst0_n       = 1'b0;
        rst1_n       = 1'b0;
        if0.req      = '0;
        if1.req      = '0;
        if0.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        if1.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        if0.eoc      = 1'b0;
        if1.eoc      = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_den",       if0.drp_den,   0);
        chk("rst_daddr",     if0.drp_daddr, 0);
        chk("rst_rsp_valid", if0.rsp_valid, 0);
        chk("rst_rsp_data",  if0.rsp_data,  0);
        chk("rst_rsp_err",   if0.rsp_err,   0);
        chk("rst_busy",      if0.busy,      0);
        chk("rst_busy_u1",   if1.busy,      0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);

        // single read, DRDY 3 cycles after DEN
        m_lat[0]   = 3;
        m_fixed[0] = 1'b1;
        m_data[0]  = 16'hA5C0;
        if0.req    = 4'b0001;
        wait_den(0, 20, n);
        chk("t1_den",   if0.drp_den,   1);
        chk("t1_daddr", if0.drp_daddr, 7'h13);
        chk("t1_busy",  if0.busy,      1);
        wait_rsp(0, 20, n, dens);
        chk("t1_latency",   n,             4);
        chk("t1_den_count", dens,          0);
        chk("t1_valid",     if0.rsp_valid, 4'b0001);
        chk("t1_data",      if0.rsp_data,  16'hA5C0);
        chk("t1_err",       if0.rsp_err,   0);
        chk("t1_busy_done", if0.busy,      0);
        if0.req = '0;
        @(negedge clk);
        chk("t1_pulse_len", if0.rsp_valid, 0);
        chk("t1_data_hold", if0.rsp_data,  16'hA5C0);

        // all requesters held, round robin starting after requester 0
        m_lat[0]   = 2;
        m_fixed[0] = 1'b0;
        if0.req    = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            idx = (k + 1) % 4;
            wait_den(0, 20, n);
            if (k > 0) chk("t2_gap", n, 2);
            chk("t2_den",   if0.drp_den,   1);
            chk("t2_daddr", if0.drp_daddr, 32'(addr_tab[idx]));
            wait_rsp(0, 20, n, dens);
            chk("t2_latency", n,             3);
            chk("t2_dens",    dens,          0);
            chk("t2_grant",   if0.rsp_valid, 32'(1) << idx);
            chk("t2_data",    if0.rsp_data,  32'h1000 | 32'(addr_tab[idx]));
        end
        if0.req = '0;
        repeat (2) @(negedge clk);

        // timeout: DRDY never arrives
        m_lat[0] = 0;
        if0.req  = 4'b0010;
        wait_den(0, 20, n);
        chk("t4_den",   if0.drp_den,   1);
        chk("t4_daddr", if0.drp_daddr, 7'h00);
        wait_rsp(0, 100, n, dens);
        chk("t4_latency", n,             65);
        chk("t4_valid",   if0.rsp_valid, 4'b0010);
        chk("t4_err",     if0.rsp_err,   1);
        chk("t4_data",    if0.rsp_data,  16'hFFFF);
        chk("t4_busy",    if0.busy,      0);
        if0.req = '0;
        @(negedge clk);
        m_lat[0] = 1;
        if0.req  = 4'b0100;
        wait_den(0, 20, n);
        chk("t4b_den", if0.drp_den, 1);
        wait_rsp(0, 20, n, dens);
        chk("t4b_latency", n,             2);
        chk("t4b_valid",   if0.rsp_valid, 4'b0100);
        chk("t4b_err",     if0.rsp_err,   0);
        chk("t4b_data",    if0.rsp_data,  16'h1001);
        if0.req = '0;
        repeat (2) @(negedge clk);

        // reset asserted while waiting for DRDY
        m_lat[0] = 0;
        if0.req  = 4'b0001;
        wait_den(0, 20, n);
        chk("t5_den", if0.drp_den, 1);
        repeat (3) @(negedge clk);
        chk("t5_busy_wait", if0.busy, 1);
        rst0_n  = 1'b0;
        if0.req = '0;
        #1;
        chk("t5_rst_den",   if0.drp_den,   0);
        chk("t5_rst_daddr", if0.drp_daddr, 0);
        chk("t5_rst_busy",  if0.busy,      0);
        chk("t5_rst_valid", if0.rsp_valid, 0);
        chk("t5_rst_data",  if0.rsp_data,  0);
        chk("t5_rst_err",   if0.rsp_err,   0);
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        repeat (2) @(negedge clk);
        m_do[0]     = 16'hBEEF;
        man_drdy[0] = 1'b1;
        @(negedge clk);
        man_drdy[0] = 1'b0;
        hits = 0;
        for (int k = 0; k < 10; k++) begin
            if (if0.rsp_valid != '0 || if0.drp_den || if0.busy) hits++;
            @(negedge clk);
        end
        chk("t5_late_drdy_ignored", hits,         0);
        chk("t5_data_after",        if0.rsp_data, 0);
        // rr pointer back at NREQ-1: requester 0 wins first
        m_lat[0] = 1;
        if0.req  = 4'b1111;
        wait_den(0, 20, n);
        chk("t5_first_daddr", if0.drp_daddr, 7'h13);
        wait_rsp(0, 20, n, dens);
        chk("t5_first_valid", if0.rsp_valid, 4'b0001);
        chk("t5_first_data",  if0.rsp_data,  16'h1013);
        wait_den(0, 20, n);
        chk("t5_second_daddr", if0.drp_daddr, 7'h00);
        wait_rsp(0, 20, n, dens);
        chk("t5_second_valid", if0.rsp_valid, 4'b0010);
        if0.req = '0;
        repeat (2) @(negedge clk);

        // EOC gating on u1
        m_lat[1]   = 2;
        m_fixed[1] = 1'b0;
        if1.req    = 4'b0001;
        dens = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (if1.drp_den) dens++;
        end
        chk("t6_no_eoc_dens", dens,     0);
        chk("t6_no_eoc_busy", if1.busy, 0);
        if1.eoc = 1'b1;
        @(negedge clk);
        if1.eoc = 1'b0;
        wait_den(1, 10, n);
        chk("t6_den_after_eoc", n,             1);
        chk("t6_daddr",         if1.drp_daddr, 7'h13);
        wait_rsp(1, 20, n, dens);
        chk("t6_latency", n,             3);
        chk("t6_valid",   if1.rsp_valid, 4'b0001);
        chk("t6_data",    if1.rsp_data,  16'h1013);
        dens = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if1.drp_den) dens++;
        end
        chk("t6_stall_dens", dens, 0);

        // EOC in the response pulse cycle keeps eoc_pend set
        if1.eoc = 1'b1;
        @(negedge clk);
        if1.eoc = 1'b0;
        wait_den(1, 10, n);
        chk("t7_den", if1.drp_den, 1);
        wait_rsp(1, 20, n, dens);
        chk("t7_valid", if1.rsp_valid, 4'b0001);
        if1.eoc = 1'b1;
        @(negedge clk);
        if1.eoc = 1'b0;
        chk("t7_den_r1", if1.drp_den, 0);
        @(negedge clk);
        chk("t7_den_r2", if1.drp_den, 1);
        wait_rsp(1, 20, n, dens);
        chk("t7_valid2", if1.rsp_valid, 4'b0001);
        chk("t7_data2",  if1.rsp_data,  16'h1013);
        dens = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (if1.drp_den) dens++;
        end
        chk("t7_stall_dens", dens, 0);
        if1.req = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xadc_drp_scheduler.md
Name: xadc_drp_scheduler

Overview:
- Shares the single XADC dynamic-reconfiguration-port (DRP) read path between NREQ independent requesters.
- Requesters are, for example, the LED mirror, the 7-seg converter and a future threshold alarm.
- Arbitrates round-robin, drives the DRP handshake (DEN/DADDR, wait for DRDY), returns the 16-bit conversion word to the winner, and recovers from a missing DRDY by timeout.
- Sits between the adc wizard instance and the consumers in the ADC top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 7, DRP address width.
- TIMEOUT, 64, cycles to wait for drp_drdy after DEN before aborting (>=4).
- WAIT_EOC, 1, if 1 a transaction starts only after an EOC pulse seen since the previous transaction completed; if 0 reads are free-running.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester read request; level, held until that requester's rsp_valid bit.
- req_addr  in  NREQ*ADDR_W  per-requester DRP address; slice i = bits [i*ADDR_W +: ADDR_W].
- rsp_valid  out  NREQ  one-cycle pulse to the served requester.
- rsp_data  out  16  DRP data for the pulsed requester; holds its value until the next response.
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout abort.
- drp_den  out  1  DEN to XADC.
- drp_daddr  out  ADDR_W  DADDR to XADC.
- drp_do  in  16  DO from XADC.
- drp_drdy  in  1  DRDY from XADC.
- eoc  in  1  EOC from XADC.
- busy  out  1  transaction in flight.

Behaviour:
- Reset (async assert, sync release): state IDLE, drp_den=0, drp_daddr=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, rr_ptr=NREQ-1, eoc_pend=0, timer=0.
- All outputs are registered.
- eoc_pend: set on eoc=1. Cleared when a transaction completes (response pulse cycle). If eoc=1 in the completion cycle, set wins.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Start condition: any req bit set and (WAIT_EOC==0 or eoc_pend).
  - Winner: first set req bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - On start, latch idx and req_addr[idx]; rr_ptr<=idx; busy<=1; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - drp_den=1 and drp_daddr=latched address, both registered and visible this cycle.
  - timer<=0; go to WAIT.
- WAIT:
  - drp_den=0; drp_daddr holds its value; timer increments.
  - If drp_drdy: next cycle rsp_data<=drp_do, rsp_err<=0, rsp_valid[idx]<=1; go to IDLE; busy<=0.
  - Else if timer==TIMEOUT-1: rsp_data<=16'hFFFF, rsp_err<=1, rsp_valid[idx]<=1; go to IDLE; busy<=0.
  - DRDY wins if drp_drdy and timeout coincide.
- Latency: req sampled in IDLE at cycle t -> den at t+1 -> drdy at t+1+k (k>=1) -> rsp_valid at t+2+k.
- Back-to-back: the earliest next DEN is 2 cycles after rsp_valid (IDLE evaluation, then ISSUE).
- req handling:
  - A requester must deassert req in the cycle after its rsp_valid; a req still high then is treated as a new request.
  - Deasserting req while a transaction is in flight does not cancel it; the response still pulses.
  - req_addr is sampled only at grant.
- drp_drdy outside WAIT is ignored, with no response and no state change.
- Reset asserted mid-transaction: immediate return to reset values, with no response pulse. A late DRDY after release is ignored (IDLE).
- Fairness: every asserting requester is served within NREQ transactions.

Decomposition:
- Shared package xadc_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - XADC DRP address constants (ADDR_TEMP=7'h00, ADDR_VCCINT=7'h01, ADDR_VAUX3=7'h13);
  - the timeout data constant 16'hFFFF.
- One sub-module is natural: rr_arbiter (NREQ request vector + pointer -> one-hot grant and index), purely combinational.
- Timer, eoc_pend and the FSM stay in the top.

Test Plan:
- WAIT_EOC=0, req=4'b0001, addr0=7'h13, XADC model returns 16'hA5C0 with drdy 3 cycles after den -> den high exactly 1 cycle with daddr=7'h13; rsp_valid=4'b0001 at t+5; rsp_data=16'hA5C0; rsp_err=0.
- All four req held high continuously, drdy latency 2 -> grant order 0,1,2,3,0,1,...; no requester served twice before all others; one DEN per transaction.
- WAIT_EOC=1, req0 high, no eoc for 100 cycles -> drp_den stays 0. Single eoc pulse -> exactly one transaction, then stall until the next eoc.
- Model never drives drdy, TIMEOUT=64 -> rsp_valid at den+65 cycles with rsp_err=1 and rsp_data=16'hFFFF. A following request proceeds normally.
- rst_n pulled low in WAIT, drdy arrives 2 cycles after release -> all outputs 0 immediately, no rsp_valid, drdy ignored, FSM in IDLE.
- eoc coincides with a completion cycle (WAIT_EOC=1) -> eoc_pend remains set; the next pending request issues den 2 cycles after rsp_valid without a further eoc.
